// File: rtl/uart_tx_core.sv
// uart_tx_core: byte-wide UART transmitter. Accepts a byte on a valid/ready
// handshake and sends start bit, 8 data bits LSB first, optional parity bit
// and 1 or 2 stop bits. Each bit lasts CLOCK_FREQ/BAUD_RATE clocks.
module uart_tx_core #(
  parameter int unsigned CLOCK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE  = 4000000,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  // tx_done/tx_ready are registered, so they are raised one clock early
  localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          accept;
  logic          bit_end;

  // tx_ready is only high in IDLE or in the final clock of the last stop bit,
  // so an accept can only happen in those two places
  assign accept  = tx_start & tx_ready;
  assign bit_end = (baud_cnt == BAUD_LAST);

  // Frame sequencer: baud counting, bit shifting and registered line/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (accept) begin
        // Load a new frame; also covers the back-to-back restart from STOP
        state     <= START;
        shreg     <= tx_data;
        par_bit   <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
        tx_serial <= 1'b0;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        tx_busy   <= 1'b1;
        tx_ready  <= 1'b0;
      end else begin
        if (state != IDLE) begin
          baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
        end
        case (state)
          IDLE: begin
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_ready  <= 1'b1;
          end
          START: begin
            if (bit_end) begin
              state     <= DATA;
              bit_cnt   <= '0;
              tx_serial <= shreg[0];
            end
          end
          DATA: begin
            if (bit_end) begin
              if (bit_cnt == 3'd7) begin
                if (PARITY_EN != 0) begin
                  state     <= PARITY;
                  tx_serial <= par_bit;
                end else begin
                  state     <= STOP;
                  bit_cnt   <= '0;
                  tx_serial <= 1'b1;
                end
              end else begin
                bit_cnt   <= bit_cnt + 3'd1;
                shreg     <= {1'b0, shreg[7:1]};
                tx_serial <= shreg[1];
              end
            end
          end
          PARITY: begin
            if (bit_end) begin
              state     <= STOP;
              bit_cnt   <= '0;
              tx_serial <= 1'b1;
            end
          end
          STOP: begin
            // Announce the final clock of the frame one edge ahead
            if ((bit_cnt == STOP_LAST) && (baud_cnt == BAUD_PRE)) begin
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
            end
            if (bit_end) begin
              if (bit_cnt != STOP_LAST) begin
                bit_cnt <= bit_cnt + 3'd1;
              end else begin
                state     <= IDLE;
                tx_busy   <= 1'b0;
                tx_ready  <= 1'b1;
                tx_serial <= 1'b1;
              end
            end
          end
          default: begin
            state     <= IDLE;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: four transmitter variants (8N1, even parity, odd parity,
// two stop bits) driven by shared stimulus and compared every clock against
// a frame-level reference model.
module tb_uart_tx_core;

  localparam int N   = 4;
  localparam int CPB = 25;
  localparam int PEN[N]   = '{0, 1, 1, 0};
  localparam int PODD[N]  = '{0, 0, 1, 0};
  localparam int NSTOP[N] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ser[N];
  logic       rdy[N];
  logic       bsy[N];
  logic       dn[N];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_core #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
  uart_tx_core #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
  uart_tx_core #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
  uart_tx_core #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_2stop (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(rdy[3]), .tx_serial(ser[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line bits, each CPB clocks long
  int          pos[N] = '{default: -1};
  logic [11:0] bits[N] = '{default: '1};
  int          done_cnt[N] = '{default: 0};

  function automatic int flen(input int i);
    return (10 + PEN[i] + NSTOP[i] - 1) * CPB;
  endfunction

  function automatic logic [11:0] frame(input logic [7:0] d, input int i);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = d[k];
    if (PEN[i] != 0) f[9] = (PODD[i] != 0) ? ~^d : ^d;
    return f;
  endfunction

  function automatic logic [3:0] exp_vec(input int i);
    logic last;
    if (pos[i] < 0) return 4'b1100;
    last = (pos[i] == flen(i) - 1);
    return {bits[i][pos[i] / CPB], last, 1'b1, last};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        pos[i] <= -1;
      end else if (tx_start && (pos[i] < 0 || pos[i] == flen(i) - 1)) begin
        pos[i]  <= 0;
        bits[i] <= frame(tx_data, i);
      end else if (pos[i] >= 0) begin
        pos[i] <= (pos[i] == flen(i) - 1) ? -1 : pos[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk($sformatf("line%0d{ser,rdy,bsy,done}", i),
          {28'd0, ser[i], rdy[i], bsy[i], dn[i]}, {28'd0, exp_vec(i)});
      if (dn[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  task automatic send_pulse(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int  base[N];
  bit  seen;

  task automatic snap();
    for (int i = 0; i < N; i++) base[i] = done_cnt[i];
  endtask

  task automatic chk_done_delta(input string tag, input int exp);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_ndone%0d", tag, i), done_cnt[i] - base[i], exp);
  endtask

  initial begin
    #13;
    chk("reset_outputs", {28'd0, ser[0], rdy[0], bsy[0], dn[0]}, 32'hC);
    idle(3);
    rst_n = 1'b1;
    idle(3);

    // 0xA5 single frame on every variant
    snap();
    send_pulse(8'hA5);
    idle(300);
    chk_done_delta("a5", 1);

    // held start: 0x00 then 0xFF back to back on the 8N1 variant
    seen = 1'b0;
    @(negedge clk);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (dn[0]) begin
        tx_data = 8'hFF;
        seen = 1'b1;
      end
    end
    chk("b2b_done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    tx_start = 1'b0;
    idle(320);

    // parity of 0x07 and 0x00, sampled mid parity bit
    send_pulse(8'h07);
    idle(237);
    chk("par07_even", {31'd0, ser[1]}, 32'd1);
    chk("par07_odd",  {31'd0, ser[2]}, 32'd0);
    idle(60);
    send_pulse(8'h00);
    idle(237);
    chk("par00_even", {31'd0, ser[1]}, 32'd0);
    chk("par00_odd",  {31'd0, ser[2]}, 32'd1);
    idle(60);

    // two stop bits: tx_done in clock 274
    send_pulse(8'h3C);
    idle(274);
    chk("stop2_done274", {31'd0, dn[3]}, 32'd1);
    chk("stop2_line", {31'd0, ser[3]}, 32'd1);
    idle(30);

    // reset during D3 of 0x81
    snap();
    send_pulse(8'h81);
    idle(110);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ser",  {31'd0, ser[0]}, 32'd1);
    chk("rst_mid_busy", {31'd0, bsy[0]}, 32'd0);
    chk("rst_mid_done", {31'd0, dn[0]},  32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    chk_done_delta("abort", 0);
    snap();
    send_pulse(8'h55);
    idle(300);
    chk_done_delta("55", 1);

    // start pulse with 0xEE mid-frame and data churn are ignored
    snap();
    send_pulse(8'h3A);
    idle(100);
    tx_data  = 8'hEE;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      tx_data = 8'($urandom);
    end
    idle(20);
    chk_done_delta("ignore", 1);

    // randomized bursts: held start, random data churn, random gaps
    for (int r = 0; r < 10; r++) begin
      int hold;
      hold = $urandom_range(1, 600);
      @(negedge clk);
      tx_data  = 8'($urandom);
      tx_start = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        tx_data = 8'($urandom);
        tx_start = ($urandom_range(0, 9) != 0);
      end
      tx_start = 1'b0;
      idle($urandom_range(0, 40));
    end
    idle(320);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
